// File: rtl/or1200_vlx_pkg.sv
// Shared types and constants for the VLX byte-store engine.
package or1200_vlx_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    STUFF = 2'd2
  } vlx_wr_state_t;

  // JPEG marker prefix; inside entropy-coded data it must be followed by a stuffed zero.
  localparam logic [7:0] VLX_MARKER_BYTE = 8'hFF;
  localparam logic [7:0] VLX_STUFF_BYTE  = 8'h00;

endpackage

// File: rtl/or1200_vlx_store_ctrl_if.sv
// Byte-in (packer) and byte-store (bus) handshakes of the VLX store controller.
interface or1200_vlx_store_ctrl_if;
  logic        byte_valid_i;
  logic [7:0]  byte_i;
  logic        byte_ready_o;
  logic        wr_req_o;
  logic [31:0] wr_addr_o;
  logic [7:0]  wr_dat_o;
  logic        ack_i;

  // Store controller side.
  modport slave (
    input  byte_valid_i, byte_i, ack_i,
    output byte_ready_o, wr_req_o, wr_addr_o, wr_dat_o
  );

  // Environment side: drives packer bytes and answers store requests.
  modport master (
    output byte_valid_i, byte_i, ack_i,
    input  byte_ready_o, wr_req_o, wr_addr_o, wr_dat_o
  );
endinterface

// File: rtl/or1200_vlx_byte_fifo.sv
// Small byte FIFO between the VLX packer and the store engine.
// Read-first: dout_o shows the head before a same-cycle pop takes effect.
module or1200_vlx_byte_fifo #(
  parameter int DEPTH = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [7:0]               din_i,
  output logic [7:0]               dout_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);
  localparam int AW = $clog2(DEPTH);

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q;
  logic          do_push, do_pop;

  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign dout_o  = mem_q[rd_ptr_q];
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  // Storage array: data only, no reset needed.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= din_i;
  end

  // Pointers and occupancy; pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end
endmodule

// File: rtl/or1200_vlx_store_ctrl.sv
// VLX byte-store scheduler: queues packed bytes, applies JPEG 0xFF/0x00
// stuffing, and issues one acknowledged byte store at a time to an
// auto-incrementing destination address.
// Build option: OR1200_VLX_STUFF_EN enables the STUFF state (zero after 0xFF);
// without it bytes are written raw.
module or1200_vlx_store_ctrl
  import or1200_vlx_pkg::*;
#(
  parameter int          FIFO_DEPTH = 4,
  parameter logic [31:0] ADDR_RST   = 32'h0000_0000
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      init_addr_we_i,
  input  logic [31:0]               init_addr_i,
  input  logic                      flush_i,
  or1200_vlx_store_ctrl_if.slave    bus,
  output logic [31:0]               addr_o,
  output logic                      busy_o,
  output logic                      stall_o
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  vlx_wr_state_t state_q, state_d;
  logic [7:0]    cur_q, cur_d;
  logic [31:0]   addr_q;
  logic          flush_pend_q;
  logic          fifo_pop, fifo_full, fifo_empty;
  logic [7:0]    fifo_dout;
  logic [CW-1:0] fifo_count;
  logic          addr_inc;
  logic          stuff_hit;

  or1200_vlx_byte_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (bus.byte_valid_i),
    .pop_i   (fifo_pop),
    .din_i   (bus.byte_i),
    .dout_o  (fifo_dout),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

`ifdef OR1200_VLX_STUFF_EN
  assign stuff_hit = (cur_q == VLX_MARKER_BYTE);
`else
  assign stuff_hit = 1'b0;
`endif

  assign bus.byte_ready_o = ~fifo_full;
  assign bus.wr_req_o     = (state_q != IDLE);
  assign bus.wr_addr_o    = addr_q;
  assign addr_o           = addr_q;
  assign busy_o           = (state_q != IDLE) | (fifo_count != '0);
  // Last term covers a producer presenting a byte the full FIFO cannot take.
  assign stall_o          = fifo_full | (flush_pend_q & busy_o) | (bus.byte_valid_i & fifo_full);

  // Store data: the queued byte in WRITE, the stuffed zero in STUFF.
  always_comb begin
    bus.wr_dat_o = 8'h00;
    case (state_q)
      WRITE:   bus.wr_dat_o = cur_q;
`ifdef OR1200_VLX_STUFF_EN
      STUFF:   bus.wr_dat_o = VLX_STUFF_BYTE;
`endif
      default: bus.wr_dat_o = 8'h00;
    endcase
  end

  // Write sequencer: fetch next byte, hold the request until ack, insert stuffing.
  always_comb begin
    state_d  = state_q;
    cur_d    = cur_q;
    fifo_pop = 1'b0;
    addr_inc = 1'b0;
    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          cur_d    = fifo_dout;
          state_d  = WRITE;
        end
      end
      WRITE: begin
        if (bus.ack_i) begin
          addr_inc = 1'b1;
          if (stuff_hit) begin
            state_d = STUFF;
          end else if (!fifo_empty) begin
            fifo_pop = 1'b1;
            cur_d    = fifo_dout;
            state_d  = WRITE;
          end else begin
            state_d = IDLE;
          end
        end
      end
`ifdef OR1200_VLX_STUFF_EN
      STUFF: begin
        if (bus.ack_i) begin
          addr_inc = 1'b1;
          if (!fifo_empty) begin
            fifo_pop = 1'b1;
            cur_d    = fifo_dout;
            state_d  = WRITE;
          end else begin
            state_d = IDLE;
          end
        end
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  // State, current byte, destination address and flush tracking.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      cur_q        <= 8'h00;
      addr_q       <= ADDR_RST;
      flush_pend_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cur_q   <= cur_d;
      // Address reload only while idle so a stream never jumps mid-way.
      if (addr_inc)
        addr_q <= addr_q + 32'd1;
      else if (init_addr_we_i && !busy_o)
        addr_q <= init_addr_i;
      if (flush_i)
        flush_pend_q <= 1'b1;
      else if (fifo_empty && (state_q == IDLE))
        flush_pend_q <= 1'b0;
    end
  end
endmodule
